// File: rtl/round_key_store.sv
// round_key_store: buffers up to NUM_KEYS expanded subkeys and streams them to
// the cipher core in forward (encrypt) or reverse (decrypt) order. The stream
// stalls on any entry the expander has not written yet.
//
// Handshake: the store holds rk_valid, rk_data, rk_round and rk_last stable
// until the core accepts with rk_ready. A beat transfers on the rising edge
// where rk_valid && rk_ready. rk_valid never depends combinationally on
// rk_ready.
module round_key_store #(
    parameter int NUM_KEYS = 15,
    parameter int KEY_W    = 128
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [3:0]          waddr,
    input  logic [KEY_W-1:0]    wdata,
    input  logic                clear_valid,
    input  logic                rd_start,
    input  logic [1:0]          key_len,
    input  logic                decrypt,
    output logic                rk_valid,
    input  logic                rk_ready,
    output logic [KEY_W-1:0]    rk_data,
    output logic [3:0]          rk_round,
    output logic                rk_last,
    output logic                busy,
    output logic [1:0]          dbg_state,
    output logic [NUM_KEYS-1:0] dbg_vbits
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SEND = 2'd2
    } state_t;

    localparam logic [3:0] LAST_ADDR = 4'(NUM_KEYS - 1);

    logic [KEY_W-1:0]    mem [NUM_KEYS];
    logic [NUM_KEYS-1:0] vbits;
    state_t              state;
    state_t              state_nxt;
    logic [3:0]          idx;
    logic [3:0]          nr_q;
    logic                dec_q;
    logic [3:0]          nr_in;
    logic [3:0]          end_idx;
    logic                start_ok;
    logic                abort;
    logic                handshake;
    logic                wr_ok;

    assign wr_ok     = wr_en && (waddr <= LAST_ADDR);
    assign start_ok  = (state == IDLE) && rd_start && (key_len != 2'b00);
    assign abort     = clear_valid && (state != IDLE);
    assign handshake = rk_valid && rk_ready;
    assign end_idx   = dec_q ? 4'd0 : nr_q;
    assign busy      = (state != IDLE);
    assign dbg_state = state;
    assign dbg_vbits = vbits;

    // Last round index for the requested key length.
    always_comb begin
        nr_in = 4'd0;
        case (key_len)
            2'b01:   nr_in = 4'd10;
            2'b10:   nr_in = 4'd12;
            2'b11:   nr_in = 4'd14;
            default: nr_in = 4'd0;
        endcase
    end

    // Subkey storage; not reset, only the valid bits qualify its contents.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[waddr] <= wdata;
        end
    end

    // Valid bits: a write wins over a coincident clear for its own address.
    always_ff @(posedge clk) begin
        if (reset) begin
            vbits <= '0;
        end else begin
            if (clear_valid) begin
                vbits <= '0;
            end
            if (wr_ok) begin
                vbits[waddr] <= 1'b1;
            end
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a clear while busy aborts from any state.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = WAIT;
            WAIT:    if (vbits[idx]) state_nxt = SEND;
            SEND:    if (handshake) state_nxt = rk_last ? IDLE : WAIT;
            default: state_nxt = IDLE;
        endcase
        if (abort) begin
            state_nxt = IDLE;
        end
    end

    // Sequence context, index stepping and the registered output beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            rk_valid <= 1'b0;
            rk_data  <= '0;
            rk_round <= 4'd0;
            rk_last  <= 1'b0;
            idx      <= 4'd0;
            nr_q     <= 4'd0;
            dec_q    <= 1'b0;
        end else if (abort) begin
            rk_valid <= 1'b0;
            rk_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        nr_q  <= nr_in;
                        dec_q <= decrypt;
                        idx   <= decrypt ? nr_in : 4'd0;
                    end
                end
                WAIT: begin
                    if (vbits[idx]) begin
                        rk_data  <= mem[idx];
                        rk_round <= idx;
                        rk_last  <= (idx == end_idx);
                        rk_valid <= 1'b1;
                    end
                end
                SEND: begin
                    if (handshake) begin
                        rk_valid <= 1'b0;
                        rk_last  <= 1'b0;
                        // The end index stops the sequence before any step past 0 or 14.
                        if (!rk_last) begin
                            idx <= dec_q ? idx - 4'd1 : idx + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_round_key_store.sv
// Bench for round_key_store: randomized subkeys, a reference model of the
// store contents and valid bits, and a scoreboard that checks every presented
// beat against the expected round sequence.
module tb_round_key_store;

  localparam int NK = 15;
  localparam int KW = 128;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [3:0]    waddr;
  logic [KW-1:0] wdata;
  logic          clear_valid;
  logic          rd_start;
  logic [1:0]    key_len;
  logic          decrypt;
  logic          rk_valid;
  logic          rk_ready;
  logic [KW-1:0] rk_data;
  logic [3:0]    rk_round;
  logic          rk_last;
  logic          busy;
  logic [1:0]    dbg_state;
  logic [NK-1:0] dbg_vbits;

  // Reference model: store contents, valid bits, expected beats {last, round, data}.
  logic [KW-1:0]  model_mem [NK];
  logic [NK-1:0]  model_valid;
  logic [132:0]   exp_q[$];
  logic           seq_active;
  int             beats_seen;
  int             vectors;
  int             miscompares;

  round_key_store #(.NUM_KEYS(NK), .KEY_W(KW)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .waddr(waddr), .wdata(wdata),
    .clear_valid(clear_valid), .rd_start(rd_start), .key_len(key_len),
    .decrypt(decrypt), .rk_valid(rk_valid), .rk_ready(rk_ready),
    .rk_data(rk_data), .rk_round(rk_round), .rk_last(rk_last), .busy(busy),
    .dbg_state(dbg_state), .dbg_vbits(dbg_vbits)
  );

  // clock / reset block
  always #5 clk = ~clk;

  function automatic logic [KW-1:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic write_key(input logic [3:0] a, input logic [KW-1:0] d);
    wr_en = 1'b1;
    waddr = a;
    wdata = d;
    if (a < 4'(NK)) begin
      model_mem[a] = d;
      model_valid[a] = 1'b1;
    end
    tick();
    wr_en = 1'b0;
  endtask

  task automatic clear_all();
    clear_valid = 1'b1;
    model_valid = '0;
    exp_q.delete();
    seq_active = 1'b0;
    tick();
    clear_valid = 1'b0;
  endtask

  task automatic start_seq(input logic [1:0] kl, input logic dec);
    int nr;
    int r;
    rd_start = 1'b1;
    key_len  = kl;
    decrypt  = dec;
    if (kl != 2'b00 && !seq_active) begin
      nr = (kl == 2'b01) ? 10 : (kl == 2'b10) ? 12 : 14;
      for (int k = 0; k <= nr; k++) begin
        r = dec ? nr - k : k;
        exp_q.push_back({(k == nr), 4'(r), model_mem[r]});
      end
      seq_active = 1'b1;
    end
    tick();
    rd_start = 1'b0;
  endtask

  task automatic wait_idle(input int bound, input bit rand_ready, output int n);
    n = 0;
    while (busy && n < bound) begin
      if (rand_ready) rk_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    vectors++;
    if (busy) begin
      miscompares++;
      $display("FAIL idle_timeout: busy still %0d after %0d cycles, expected 0", busy, n);
    end
  endtask

  task automatic wait_valid(input int bound);
    int n;
    n = 0;
    while (!rk_valid && n < bound) begin
      tick();
      n++;
    end
    vectors++;
    if (!rk_valid) begin
      miscompares++;
      $display("FAIL valid_timeout: rk_valid %0d after %0d cycles, expected 1", rk_valid, n);
    end
  endtask

  // scoreboard monitor: every presented beat must match the queue head;
  // the head is retired when the core accepts it.
  always @(negedge clk) begin
    if (!reset && rk_valid) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL beat: unexpected round %0d data %0h, expected no beat", rk_round, rk_data);
      end else begin
        if ({rk_last, rk_round, rk_data} !== exp_q[0]) begin
          miscompares++;
          $display("FAIL beat: got last=%0d round=%0d data=%0h, expected last=%0d round=%0d data=%0h",
                   rk_last, rk_round, rk_data, exp_q[0][132], exp_q[0][131:128], exp_q[0][127:0]);
        end
        if (rk_ready) begin
          if (exp_q[0][132]) seq_active = 1'b0;
          void'(exp_q.pop_front());
          beats_seen++;
        end
      end
    end
  end

  initial begin
    int n;
    vectors = 0; miscompares = 0; beats_seen = 0;
    seq_active = 1'b0; model_valid = '0;
    reset = 1'b1; wr_en = 1'b0; waddr = '0; wdata = '0; clear_valid = 1'b0;
    rd_start = 1'b0; key_len = 2'b00; decrypt = 1'b0; rk_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // reset state
    check("reset_outputs", {rk_valid, rk_round, rk_last, busy, dbg_state}, 0);
    check("reset_data", rk_data, 0);
    check("reset_vbits", dbg_vbits, 0);

    // AES-128 encrypt, mem[i] = i replicated, always ready
    for (int i = 0; i <= 10; i++) write_key(4'(i), {16{8'(i)}});
    rk_ready = 1'b1;
    start_seq(2'b01, 1'b0);
    check("start_busy", busy, 1);
    check("start_valid_early", rk_valid, 0);
    tick();
    check("start_valid_t2", rk_valid, 1);
    wait_idle(100, 1'b0, n);
    check("enc128_busy_cycles", n + 1, 22);
    check("enc128_drained", exp_q.size(), 0);

    // AES-256 decrypt with random ready
    for (int i = 0; i < NK; i++) write_key(4'(i), rand_key());
    check("vbits_full", dbg_vbits, model_valid);
    start_seq(2'b11, 1'b1);
    wait_idle(300, 1'b1, n);
    check("dec256_drained", exp_q.size(), 0);

    // ignored requests: key_len=00, out-of-range write, rd_start while busy
    rk_ready = 1'b0;
    start_seq(2'b00, 1'b0);
    tick();
    check("kl00_ignored", {busy, rk_valid, dbg_state}, 0);
    write_key(4'd15, rand_key());
    check("waddr15_dropped", dbg_vbits, model_valid);
    start_seq(2'b10, 1'b0);
    wait_valid(20);
    start_seq(2'b01, 1'b1);
    repeat (3) tick();
    rk_ready = 1'b1;
    wait_idle(100, 1'b0, n);
    check("busy_start_ignored", exp_q.size(), 0);

    // abort at beat 5 with a coincident write to entry 2
    beats_seen = 0;
    start_seq(2'b01, 1'b0);
    n = 0;
    while (beats_seen < 5 && n < 100) begin tick(); n++; end
    check("abort_reach_beat5", beats_seen, 5);
    clear_valid = 1'b1;
    wr_en = 1'b1; waddr = 4'd2; wdata = rand_key();
    model_valid = '0; model_valid[2] = 1'b1; model_mem[2] = wdata;
    exp_q.delete(); seq_active = 1'b0;
    tick();
    clear_valid = 1'b0; wr_en = 1'b0;
    check("abort_outputs", {rk_valid, busy, dbg_state}, 0);
    check("abort_vbits", dbg_vbits, 15'h0004);

    // AES-192 encrypt started on an empty store, writes every third cycle
    clear_all();
    for (int i = 0; i <= 12; i++) model_mem[i] = rand_key();
    start_seq(2'b10, 1'b0);
    for (int i = 0; i <= 12; i++) begin
      write_key(4'(i), model_mem[i]);
      check("stall_no_early_valid", rk_valid, 0);
      tick();
      check("stall_valid_t2", {rk_valid, rk_round}, {1'b1, 4'(i)});
      tick();
    end
    check("stall_drained", {busy, 32'(exp_q.size())}, 0);

    // reset while in SEND, then a restart that waits for rewritten entries
    rk_ready = 1'b0;
    start_seq(2'b01, 1'b0);
    wait_valid(20);
    tick();
    reset = 1'b1;
    exp_q.delete(); seq_active = 1'b0; model_valid = '0;
    tick();
    reset = 1'b0;
    check("midreset_outputs", {rk_valid, rk_round, rk_last, busy, dbg_state}, 0);
    check("midreset_data", rk_data, 0);
    check("midreset_vbits", dbg_vbits, 0);
    for (int i = 0; i <= 10; i++) model_mem[i] = rand_key();
    rk_ready = 1'b1;
    start_seq(2'b01, 1'b0);
    repeat (5) tick();
    check("restart_waiting", {rk_valid, dbg_state}, {1'b0, 2'd1});
    for (int i = 0; i <= 10; i++) write_key(4'(i), model_mem[i]);
    wait_idle(100, 1'b0, n);
    check("restart_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/round_key_store.md
# round_key_store

Round-key buffer sitting between the key-expansion front end and the AES round datapath. It captures subkeys written by the key expander (write strobe, 4-bit address, 128-bit subkey, clear-valid pulse) into a 15-entry store with per-entry valid bits. On request, it streams them to the cipher core over a valid/ready handshake, in forward order for encryption and reverse order for decryption. A sequencer stalls on any entry not yet written, so the core can start a block while expansion is still in progress.

## Interface
- NUM_KEYS, 15, number of subkey entries (Nr+1 for AES-256)
- KEY_W, 128, subkey width
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- wr_en  in  1  subkey write strobe (from expander valid)
- waddr  in  4  subkey index 0..14
- wdata  in  KEY_W  subkey value
- clear_valid  in  1  clears all valid bits (new key being expanded)
- rd_start  in  1  one-cycle pulse: begin streaming round keys
- key_len  in  2  01=AES-128, 10=AES-192, 11=AES-256, 00=none; sampled on rd_start
- decrypt  in  1  0=stream 0..Nr, 1=stream Nr..0; sampled on rd_start
- rk_valid  out  1  rk_data/rk_round valid
- rk_ready  in  1  core accepts current round key
- rk_data  out  KEY_W  round key
- rk_round  out  4  index of the round key currently presented
- rk_last  out  1  high with the final beat of a sequence
- busy  out  1  sequence in progress (state != IDLE)

## Operation
- Storage: mem[0..14] (no reset), vbits[14:0].
- Write: wr_en with waddr<=14 writes mem[waddr] and sets vbits[waddr]. Writes with waddr>14 are dropped.
- Writes and clear_valid are accepted in every FSM state.
- clear_valid clears all vbits. If wr_en occurs in the same cycle, that write's bit is set anyway: write has priority for its address.
- Nr = 10/12/14 for key_len 01/10/11.
- rd_start with key_len=00, or while busy, is ignored.
- FSM states: IDLE, WAIT, SEND.
  - IDLE: on rd_start (valid key_len), latch Nr and decrypt, set idx = decrypt ? Nr : 0, then go to WAIT.
  - WAIT: if vbits[idx], register rk_data<=mem[idx], rk_round<=idx, rk_last<=(idx==end index), rk_valid<=1, then go to SEND. Otherwise stay in WAIT. A write landing in the same cycle is seen in the following cycle.
  - SEND: outputs held stable while rk_ready=0. On rk_valid&&rk_ready:
    - if rk_last, go to IDLE;
    - else idx steps +1 (encrypt) or -1 (decrypt), and go to WAIT.
    - rk_valid drops the cycle after the handshake.
- Abort: clear_valid while busy (any state) returns the FSM to IDLE with rk_valid=0 next cycle. The core must re-issue rd_start.
- Index arithmetic is 4-bit. It never wraps: the end index (Nr or 0) terminates the sequence before any step past 0 or 14.

## Timing
- Reset values: rk_valid=0, rk_data=0, rk_round=0, rk_last=0, busy=0, vbits=0, state=IDLE.
- rd_start at cycle T with the entry already valid: busy=1 at T+1, rk_valid=1 at T+2.
- Handshake at cycle T: the next key is valid at T+2 if its entry is valid. That gives one bubble per beat, so the minimum sequence is 2*(Nr+1) cycles.
- Entry written at cycle T while WAIT is pending on it: rk_valid at T+2.
- Final handshake at T: busy=0 and rk_valid=0 at T+1; a new rd_start is accepted at T+1.
- reset mid-sequence: all outputs at reset values on the next cycle, and all vbits cleared.

## Test plan
- Preload 0..10 (mem[i]=i replicated), key_len=01, decrypt=0, rk_ready=1 -> rk_round 0..10 in order, rk_data matches, rk_last only with round 10, busy low after 22 cycles.
- key_len=11, decrypt=1, all 15 entries valid, rk_ready toggling 1/0 -> rounds 14..0, data held stable while rk_ready=0, no beat lost or duplicated.
- rd_start with vbits empty, then writes at 3-cycle intervals from index 0 (192-bit, Nr=12) -> each rk_valid two cycles after the matching write, 13 beats total.
- Mid-sequence clear_valid at beat 5 -> rk_valid=0 next cycle, busy=0, vbits=0. A write coincident with clear_valid at waddr=2 leaves only vbits[2]=1.
- rd_start with key_len=00, rd_start while busy, and a write at waddr=15 -> all ignored; state, vbits and outputs unchanged.
- reset asserted while in SEND -> next cycle all outputs 0 and state IDLE. A following rd_start waits in WAIT until entries are rewritten.
